// File: rtl/riscv_hazard_ctrl.sv
// Hazard/pipeline control for the 5-stage core: RAW stalls, bus-stall freeze, redirect flush.
// Define RISCV_HAZARD_FWD_EN to stall only on load-use and drive registered forwarding selects.
module riscv_hazard_ctrl #(
   parameter int REG_AW    = 5,
   parameter int FLUSH_CYC = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_src1_en,
   input  logic              i_src2_en,
   input  logic [REG_AW-1:0] i_src1_addr,
   input  logic [REG_AW-1:0] i_src2_addr,
   input  logic              i_dst_en,
   input  logic [REG_AW-1:0] i_dst_addr,
   input  logic              i_dst_is_load,
   input  logic              i_redirect,
   input  logic              i_bus_stall,
   input  logic              i_cnt_clr,
   output logic              o_stall_f,
   output logic              o_stall_fd,
   output logic              o_stall_de,
   output logic              o_stall_em,
   output logic              o_flush_fd,
   output logic              o_flush_de,
   output logic              o_flush_em,
   output logic              o_flush_mb,
   output logic [1:0]        o_fwd1_sel,
   output logic [1:0]        o_fwd2_sel,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   typedef enum logic [1:0] {RUN, FREEZE, FLUSH} state_t;

   state_t             state_q, state_d;
   logic [3:0]         fcnt_q, fcnt_d;
   logic               e_vld_q, e_vld_d, e_ld_q, e_ld_d, m_vld_q, m_vld_d;
   logic [REG_AW-1:0]  e_addr_q, e_addr_d, m_addr_q, m_addr_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic stall_f, stall_fd, stall_de, stall_em;
   logic flush_fd, flush_de, flush_em, flush_mb;
   logic flushing, raw_haz, cnt_evt;
   logic e_hit1, e_hit2, m_hit1, m_hit2;

   function automatic logic src_hit(input logic en, input logic [REG_AW-1:0] a,
                                    input logic vld, input logic [REG_AW-1:0] sa);
      return en && (a != '0) && vld && (a == sa);
   endfunction

   // B needs no shadow: the regfile is write-through, so a producer in B never stalls D.
   assign e_hit1 = src_hit(i_src1_en, i_src1_addr, e_vld_q, e_addr_q);
   assign e_hit2 = src_hit(i_src2_en, i_src2_addr, e_vld_q, e_addr_q);
   assign m_hit1 = src_hit(i_src1_en, i_src1_addr, m_vld_q, m_addr_q);
   assign m_hit2 = src_hit(i_src2_en, i_src2_addr, m_vld_q, m_addr_q);

`ifdef RISCV_HAZARD_FWD_EN
   assign raw_haz = (e_hit1 || e_hit2) && e_ld_q;
`else
   logic unused_ld;
   assign raw_haz   = e_hit1 || e_hit2 || m_hit1 || m_hit2;
   assign unused_ld = e_ld_q;
`endif

   // A freeze that interrupted a flush leaves the remaining count behind to resume.
   assign flushing = (state_q == FLUSH) || ((state_q == FREEZE) && (fcnt_q != '0));

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      stall_f  = 1'b0;
      stall_fd = 1'b0;
      stall_de = 1'b0;
      stall_em = 1'b0;
      flush_fd = 1'b0;
      flush_de = 1'b0;
      flush_em = 1'b0;
      flush_mb = 1'b0;
      cnt_evt  = 1'b0;
      if (i_bus_stall) begin
         state_d  = FREEZE;
         stall_f  = 1'b1;
         stall_fd = 1'b1;
         stall_de = 1'b1;
         stall_em = 1'b1;
         flush_mb = 1'b1;
      end else if (flushing) begin
         flush_fd = 1'b1;
         fcnt_d   = fcnt_q - 4'd1;
         state_d  = (fcnt_q == 4'd1) ? RUN : FLUSH;
      end else if (i_redirect) begin
         flush_fd = 1'b1;
         flush_de = 1'b1;
         flush_em = 1'b1;
         fcnt_d   = 4'(FLUSH_CYC - 1);
         state_d  = (FLUSH_CYC > 1) ? FLUSH : RUN;
      end else begin
         state_d = RUN;
         if (raw_haz) begin
            stall_f  = 1'b1;
            stall_fd = 1'b1;
            flush_de = 1'b1;
            cnt_evt  = 1'b1;
         end
      end
   end

   always_comb begin
      e_vld_d  = e_vld_q;
      e_addr_d = e_addr_q;
      e_ld_d   = e_ld_q;
      m_vld_d  = m_vld_q;
      m_addr_d = m_addr_q;
      if (!i_bus_stall) begin
         e_vld_d  = i_dst_en && (i_dst_addr != '0) && !flush_de;
         e_addr_d = i_dst_addr;
         e_ld_d   = i_dst_is_load;
         m_vld_d  = e_vld_q && !flush_em;
         m_addr_d = e_addr_q;
      end
      stall_cnt_d = stall_cnt_q;
      if (i_cnt_clr)
         stall_cnt_d = '0;
      else if (cnt_evt && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         fcnt_q      <= '0;
         e_vld_q     <= 1'b0;
         e_addr_q    <= '0;
         e_ld_q      <= 1'b0;
         m_vld_q     <= 1'b0;
         m_addr_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         e_vld_q     <= e_vld_d;
         e_addr_q    <= e_addr_d;
         e_ld_q      <= e_ld_d;
         m_vld_q     <= m_vld_d;
         m_addr_q    <= m_addr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef RISCV_HAZARD_FWD_EN
   logic [1:0] fwd1_sel_q, fwd1_sel_d, fwd2_sel_q, fwd2_sel_d;

   // Producer in E now sits in M when the consumer reaches E (1); producer in M sits in B (2).
   always_comb begin
      fwd1_sel_d = fwd1_sel_q;
      fwd2_sel_d = fwd2_sel_q;
      if (!i_bus_stall) begin
         fwd1_sel_d = flush_de ? 2'd0 : e_hit1 ? 2'd1 : m_hit1 ? 2'd2 : 2'd0;
         fwd2_sel_d = flush_de ? 2'd0 : e_hit2 ? 2'd1 : m_hit2 ? 2'd2 : 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd1_sel_q <= 2'd0;
         fwd2_sel_q <= 2'd0;
      end else begin
         fwd1_sel_q <= fwd1_sel_d;
         fwd2_sel_q <= fwd2_sel_d;
      end
   end

   assign o_fwd1_sel = fwd1_sel_q;
   assign o_fwd2_sel = fwd2_sel_q;
`else
   assign o_fwd1_sel = 2'd0;
   assign o_fwd2_sel = 2'd0;
`endif

   assign o_stall_f   = stall_f  & rst_n;
   assign o_stall_fd  = stall_fd & rst_n;
   assign o_stall_de  = stall_de & rst_n;
   assign o_stall_em  = stall_em & rst_n;
   assign o_flush_fd  = flush_fd & rst_n;
   assign o_flush_de  = flush_de & rst_n;
   assign o_flush_em  = flush_em & rst_n;
   assign o_flush_mb  = flush_mb & rst_n;
   assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl (FLUSH_CYC=3, CNT_W=2): directed vectors, a per-cycle model and literal pins.
module tb_riscv_hazard_ctrl;
   localparam int AW = 5;
   localparam int FC = 3;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s1e = 0, s2e = 0, de = 0, dl = 0, redir = 0, bus = 0, clr = 0;
   logic [AW-1:0] s1a = 0, s2a = 0, da = 0;
   logic          sf, sfd, sde, sem, ffd, fde, fem, fmb;
   logic [1:0]    f1, f2;
   logic [CW-1:0] cnt;
   logic [7:0]    outs;
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   riscv_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYC(FC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_src1_en(s1e), .i_src2_en(s2e), .i_src1_addr(s1a), .i_src2_addr(s2a),
      .i_dst_en(de), .i_dst_addr(da), .i_dst_is_load(dl),
      .i_redirect(redir), .i_bus_stall(bus), .i_cnt_clr(clr),
      .o_stall_f(sf), .o_stall_fd(sfd), .o_stall_de(sde), .o_stall_em(sem),
      .o_flush_fd(ffd), .o_flush_de(fde), .o_flush_em(fem), .o_flush_mb(fmb),
      .o_fwd1_sel(f1), .o_fwd2_sel(f2), .o_stall_cnt(cnt)
   );

   // {stall_f, stall_fd, stall_de, stall_em, flush_fd, flush_de, flush_em, flush_mb}
   assign outs = {sf, sfd, sde, sem, ffd, fde, fem, fmb};

   localparam logic [7:0] O_IDLE = 8'h00;
   localparam logic [7:0] O_HAZ  = 8'b1100_0100;
   localparam logic [7:0] O_FRZ  = 8'b1111_0001;
   localparam logic [7:0] O_RED  = 8'b0000_1110;
   localparam logic [7:0] O_FLS  = 8'b0000_1000;

`ifdef RISCV_HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {bit v; bit [AW-1:0] a; bit ld;} slot_t;
   slot_t pipe [2];          // [0] = instruction in E, [1] = instruction in M
   int    flush_left = 0;    // FD-only bubbles still owed by the last redirect
   int    m_cnt = 0;
   int    m_sel1 = 0, m_sel2 = 0;

   function automatic bit hits(bit en, bit [AW-1:0] a, slot_t s, bit need_ld);
      return en && (a != 0) && s.v && (s.a == a) && (!need_ld || s.ld);
   endfunction

   function automatic int sel_for(bit en, bit [AW-1:0] a, slot_t e, slot_t m);
      if (hits(en, a, e, 1'b0)) return 1;
      if (hits(en, a, m, 1'b0)) return 2;
      return 0;
   endfunction

   initial begin
      bit frz, fl, rd, hz, uses;
      slot_t empty;
      empty = '{v: 1'b0, a: '0, ld: 1'b0};
      pipe[0] = empty;
      pipe[1] = empty;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("reset_outs", int'(outs), 0);
            chk("reset_cnt", int'(cnt), 0);
            chk("reset_fwd", int'({f1, f2}), 0);
            pipe[0] = empty; pipe[1] = empty;
            flush_left = 0; m_cnt = 0; m_sel1 = 0; m_sel2 = 0;
         end else begin
            frz = bus;
            fl  = !frz && (flush_left > 0);
            rd  = !frz && !fl && redir;
            if (FWD)
               uses = hits(s1e, s1a, pipe[0], 1'b1) || hits(s2e, s2a, pipe[0], 1'b1);
            else
               uses = hits(s1e, s1a, pipe[0], 1'b0) || hits(s2e, s2a, pipe[0], 1'b0) ||
                      hits(s1e, s1a, pipe[1], 1'b0) || hits(s2e, s2a, pipe[1], 1'b0);
            hz = !frz && !fl && !rd && uses;
            chk("cyc_outs", int'(outs),
                int'({frz | hz, frz | hz, frz, frz, fl | rd, rd | hz, rd, frz}));
            chk("cyc_cnt", int'(cnt), m_cnt);
            chk("cyc_fwd1", int'(f1), m_sel1);
            chk("cyc_fwd2", int'(f2), m_sel2);
            if (!frz) begin
               if (FWD) begin
                  m_sel1 = (rd || hz) ? 0 : sel_for(s1e, s1a, pipe[0], pipe[1]);
                  m_sel2 = (rd || hz) ? 0 : sel_for(s2e, s2a, pipe[0], pipe[1]);
               end
               pipe[1] = rd ? empty : pipe[0];
               pipe[0] = (rd || hz) ? empty : '{v: de && (da != 0), a: da, ld: dl};
               if (rd) flush_left = FC - 1;
               else if (fl) flush_left--;
            end
            if (clr) m_cnt = 0;
            else if (hz && m_cnt < (1 << CW) - 1) m_cnt++;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      s1e = 0; s2e = 0; s1a = 0; s2a = 0; de = 0; da = 0; dl = 0;
      redir = 0; bus = 0; clr = 0;
   endtask

   task automatic see(input string name, input logic [7:0] exp);
      #1;
      chk(name, int'(outs), int'(exp));
   endtask

   task automatic load_use(input logic [AW-1:0] r);
      tick; idle; de = 1; da = r; dl = 1;
      tick; idle; s1e = 1; s1a = r;
      tick;
      tick; idle;
   endtask

   initial begin
      idle;
      repeat (2) tick;
      see("rst_idle", O_IDLE);
      chk("rst_cnt", int'(cnt), 0);
      rst_n = 1;

      // producer x5 then consumer x5
      tick; idle; de = 1; da = 5;
      tick; idle; s1e = 1; s1a = 5;
      see("raw_in_e", FWD ? O_IDLE : O_HAZ);
      tick;
      see("raw_in_m", FWD ? O_IDLE : O_HAZ);
      if (FWD) chk("fwd_alu_sel", int'(f1), 1);
      tick;
      see("raw_released", O_IDLE);
      chk("stall_cnt_2", int'(cnt), FWD ? 0 : 2);
      tick; idle;

      // load x3 then consumer x3
      tick; idle; de = 1; da = 3; dl = 1;
      tick; idle; s1e = 1; s1a = 3;
      see("loaduse_c0", O_HAZ);
      tick;
      see("loaduse_c1", FWD ? O_IDLE : O_HAZ);
      tick;
      see("loaduse_c2", O_IDLE);
      if (FWD) chk("fwd_load_sel", int'(f1), 2);
      tick; idle;

      // saturation then clear-wins
      load_use(5'd9);
      load_use(5'd11);
      load_use(5'd12);
      chk("cnt_sat", int'(cnt), 3);
      tick; idle; de = 1; da = 10; dl = 1;
      tick; idle; s1e = 1; s1a = 10; clr = 1;
      see("clr_haz", O_HAZ);
      tick; clr = 0;
      chk("cnt_clr_wins", int'(cnt), 0);
      tick; idle;

      // x0 never stalls
      tick; idle; de = 1; da = 0;
      tick; idle; s1e = 1; s1a = 0; s2e = 1; s2a = 0;
      see("x0_no_stall", O_IDLE);
      tick; idle;

      // redirect with E/M populated
      tick; idle; de = 1; da = 7;
      tick; idle; de = 1; da = 8;
      tick; idle; redir = 1;
      see("redir_c0", O_RED);
      tick; idle;
      see("redir_c1", O_FLS);
      tick;
      see("redir_c2", O_FLS);
      tick; idle; s1e = 1; s1a = 8; s2e = 1; s2a = 7;
      see("redir_no_spurious", O_IDLE);
      tick; idle;

      // bus stall during flush cycle 1
      tick; idle; redir = 1;
      see("frzfl_c0", O_RED);
      tick; idle; bus = 1;
      for (int i = 0; i < 4; i++) begin
         see("frz_in_flush", O_FRZ);
         if (i < 3) tick;
      end
      tick; idle;
      see("flush_resume_1", O_FLS);
      tick;
      see("flush_resume_2", O_FLS);
      tick;
      see("flush_done", O_IDLE);

      // bus stall with redirect held
      tick; idle; bus = 1; redir = 1;
      for (int i = 0; i < 3; i++) begin
         see("frz_over_redir", O_FRZ);
         tick;
      end
      bus = 0;
      see("redir_after_frz", O_RED);
      tick; idle;
      see("late_flush_1", O_FLS);
      tick;
      see("late_flush_2", O_FLS);
      tick;
      see("late_flush_done", O_IDLE);

      // reset in the middle of a flush
      tick; idle; redir = 1;
      tick; idle;
      see("pre_rst_flush", O_FLS);
      rst_n = 0;
      see("rst_mid_flush", O_IDLE);
      chk("rst_mid_cnt", int'(cnt), 0);
      tick;
      tick; rst_n = 1;
      see("post_rst_run", O_IDLE);
      tick;
      see("post_rst_run2", O_IDLE);
      tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
